// File: rtl/robo_controlador.sv
// Left-hand-rule sequencing controller for the maze robot: one-hot actuator
// commands over valid/ready, with a move budget and multi-step right turns.
module robo_controlador #(
    parameter int CNT_W         = 8,
    parameter int SETTLE_CYCLES = 1,
    parameter int TURN_STEPS    = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] max_moves,
    input  logic             head,
    input  logic             left,
    input  logic             under,
    input  logic             barrier,
    input  logic             act_ready,
    output logic             avancar,
    output logic             girar,
    output logic             remover,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] move_count
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = (TURN_STEPS > 1) ? $clog2(TURN_STEPS) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TURN_LAST   = TW'(TURN_STEPS - 1);

    typedef enum logic [2:0] {IDLE, DECIDE, ISSUE, SETTLE, DONE} state_t;
    typedef enum logic {SEARCH, FOLLOW} mode_t;

    // Command bundle packed as {remover, girar, avancar}
    typedef struct packed {
        logic [2:0]    cmd;
        logic [TW-1:0] turn;
        logic          lt;
        mode_t         mode;
    } decision_t;

    localparam logic [2:0] CMD_AV  = 3'b001;
    localparam logic [2:0] CMD_GI  = 3'b010;
    localparam logic [2:0] CMD_REM = 3'b100;

    state_t         state;
    mode_t          mode;
    logic           lt_flag;
    logic [CNT_W-1:0] remaining;
    logic [TW-1:0]  turn_cnt;
    logic [SW-1:0]  settle_cnt;
    decision_t      dec;

    always_comb begin
        dec.cmd  = CMD_GI;
        dec.turn = '0;
        dec.lt   = lt_flag;
        dec.mode = mode;
        if (mode == SEARCH) begin
            if (under)              dec.cmd = CMD_REM;
            else if (!head)         dec.cmd = CMD_AV;
            else if (barrier)       dec.cmd = CMD_REM;
            else begin
                dec.turn = TURN_LAST;
                dec.mode = FOLLOW;
            end
        end else begin
            if (under)                  dec.cmd = CMD_REM;
            else if (!left && !lt_flag) dec.lt  = 1'b1;
            else if (!head) begin
                dec.cmd = CMD_AV;
                dec.lt  = 1'b0;
            end
            else if (barrier)           dec.cmd = CMD_REM;
            else begin
                dec.turn = TURN_LAST;
                dec.lt   = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            mode       <= SEARCH;
            lt_flag    <= 1'b0;
            remaining  <= '0;
            turn_cnt   <= '0;
            settle_cnt <= '0;
            avancar    <= 1'b0;
            girar      <= 1'b0;
            remover    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            move_count <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    remaining  <= max_moves;
                    move_count <= '0;
                    mode       <= SEARCH;
                    lt_flag    <= 1'b0;
                    turn_cnt   <= '0;
                    if (max_moves == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= DECIDE;
                        busy  <= 1'b1;
                    end
                end
                DECIDE: begin
                    {remover, girar, avancar} <= dec.cmd;
                    turn_cnt <= dec.turn;
                    lt_flag  <= dec.lt;
                    mode     <= dec.mode;
                    state    <= ISSUE;
                end
                ISSUE: if (act_ready) begin
                    {remover, girar, avancar} <= 3'b000;
                    if (move_count != '1)
                        move_count <= move_count + CNT_W'(1);
                    remaining <= remaining - CNT_W'(1);
                    // Budget can run out mid-turn; leftover turn steps are dropped
                    if (remaining == CNT_W'(1)) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        turn_cnt <= '0;
                    end else begin
                        state      <= SETTLE;
                        settle_cnt <= SETTLE_LAST;
                    end
                end
                SETTLE: begin
                    if (settle_cnt != '0)
                        settle_cnt <= settle_cnt - SW'(1);
                    else if (turn_cnt != '0) begin
                        girar    <= 1'b1;
                        turn_cnt <= turn_cnt - TW'(1);
                        state    <= ISSUE;
                    end else
                        state <= DECIDE;
                end
                DONE: if (!start) begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_robo_controlador.sv
// Directed bench for robo_controlador; accepted commands are matched against
// a queue of expected commands pushed as each scenario is set up.
module tb_robo_controlador;

    localparam int CNT_W = 8;
    localparam logic [2:0] C_AV = 3'b001, C_GI = 3'b010, C_RE = 3'b100;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] max_moves = '0;
    logic             head = 1'b0, left = 1'b0, under = 1'b0, barrier = 1'b0;
    logic             act_ready = 1'b0;
    logic             avancar, girar, remover, busy, done;
    logic [CNT_W-1:0] move_count;

    int errors = 0;
    int checks = 0;
    logic [2:0] sb[$];

    robo_controlador #(.CNT_W(CNT_W), .SETTLE_CYCLES(1), .TURN_STEPS(3)) dut (
        .clock(clock), .reset(reset), .start(start), .max_moves(max_moves),
        .head(head), .left(left), .under(under), .barrier(barrier),
        .act_ready(act_ready), .avancar(avancar), .girar(girar),
        .remover(remover), .busy(busy), .done(done), .move_count(move_count)
    );

    always #5 clock = ~clock;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs observed 1ns after the edge.
    task automatic tick();
        logic [2:0] cmd;
        logic [2:0] exp_cmd;
        logic       acc;
        cmd = {remover, girar, avancar};
        acc = reset && act_ready && (cmd != 3'b000);
        @(posedge clock);
        #1;
        if (acc) begin
            exp_cmd = (sb.size() != 0) ? sb.pop_front() : 3'b000;
            chkn("sb_accept", int'(cmd), int'(exp_cmd));
        end
        chk1("onehot", $countones({remover, girar, avancar}) <= 1, 1'b1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chkn({tag, "_cmd"}, int'({remover, girar, avancar}), 0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chkn({tag, "_cnt"}, int'(move_count), 0);
    endtask

    initial begin
        int gcnt;
        int cyc;

        // Reset state
        tick();
        tick();
        chk_idle_outputs("reset");

        // Mid-run reset drops the pending avancar
        reset = 1'b1;
        start = 1'b1; max_moves = 8'd10; act_ready = 1'b0;
        tick();
        start = 1'b0;
        tick();
        chk1("t1_av_high", avancar, 1'b1);
        chk1("t1_busy", busy, 1'b1);
        reset = 1'b0;
        tick();
        chk_idle_outputs("t1_after_rst");
        reset = 1'b1;
        tick();

        // Open field: three avancar, 3 cycles apart
        act_ready = 1'b1; start = 1'b1; max_moves = 8'd3;
        repeat (3) sb.push_back(C_AV);
        tick();
        start = 1'b0;
        chk1("t3_busy", busy, 1'b1);
        chk1("t3_av_decide", avancar, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk1("t3_av_pulse", avancar, 1'b1);
            tick();
            if (i < 2) begin
                chk1("t3_av_gap1", avancar, 1'b0);
                tick();
                chk1("t3_av_gap2", avancar, 1'b0);
                tick();
            end
        end
        chk1("t3_done", done, 1'b1);
        chk1("t3_busy_end", busy, 1'b0);
        chkn("t3_count", int'(move_count), 3);
        tick();
        chk1("t3_done_drop", done, 1'b0);

        // Zero budget
        start = 1'b1; max_moves = 8'd0;
        tick();
        chk1("t2_done", done, 1'b1);
        chk1("t2_busy", busy, 1'b0);
        tick();
        chk1("t2_done_held", done, 1'b1);
        chkn("t2_cmd", int'({remover, girar, avancar}), 0);
        start = 1'b0;
        tick();
        chk1("t2_done_drop", done, 1'b0);

        // Wall hit: three girar regardless of sensor noise, then FOLLOW
        start = 1'b1; max_moves = 8'd20; head = 1'b1; barrier = 1'b0;
        repeat (3) sb.push_back(C_GI);
        tick();
        start = 1'b0;
        gcnt = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (girar) gcnt++;
            head = 1'($urandom_range(0, 1));
            left = 1'($urandom_range(0, 1));
        end
        chkn("t4_girar_count", gcnt, 3);
        chkn("t4_count3", int'(move_count), 3);
        head = 1'b0; left = 1'b0;
        sb.push_back(C_GI);
        tick();
        chk1("t4_free_left", girar, 1'b1);
        sb.push_back(C_AV);
        tick();
        tick();
        tick();
        chk1("t4_lt_blocks", avancar, 1'b1);
        chk1("t4_no_girar", girar, 1'b0);
        tick();
        chkn("t4_count5", int'(move_count), 5);

        // Handshake stall and under priority
        under = 1'b1; head = 1'b0; act_ready = 1'b0;
        sb.push_back(C_RE);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chkn("t5_rem_stable", int'({remover, girar, avancar}), int'(C_RE));
            chkn("t5_cnt_hold", int'(move_count), 5);
            if (i < 4) tick();
        end
        act_ready = 1'b1;
        tick();
        chkn("t5_cnt_inc", int'(move_count), 6);
        chk1("t5_rem_clear", remover, 1'b0);
        under = 1'b0; head = 1'b1; barrier = 1'b1; left = 1'b1;
        sb.push_back(C_RE);
        tick();
        tick();
        chk1("t5_barrier_rem", remover, 1'b1);
        tick();
        chkn("t5_cnt7", int'(move_count), 7);
        chk1("t5_still_busy", busy, 1'b1);

        // Fresh run: two budget units left when FOLLOW starts its right turn
        reset = 1'b0;
        tick();
        reset = 1'b1;
        head = 1'b1; left = 1'b1; barrier = 1'b0; under = 1'b0;
        start = 1'b1; max_moves = 8'd5;
        repeat (5) sb.push_back(C_GI);
        gcnt = 0;
        cyc = 0;
        tick();
        while (!done && cyc < 60) begin
            tick();
            if (girar) gcnt++;
            cyc++;
        end
        chk1("t6_done_reached", done, 1'b1);
        chkn("t6_girar_count", gcnt, 5);
        chkn("t6_count", int'(move_count), 5);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("t6_done_held", done, 1'b1);
            chk1("t6_no_cmd", girar | avancar | remover, 1'b0);
        end
        start = 1'b0;
        tick();
        chk1("t6_done_drop", done, 1'b0);
        chkn("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/robo_controlador.md
Name: robo_controlador

Overview:
- Sequencing controller for the maze robot. Follows the wall with the left-hand rule, using sensors head, left, under and barrier, and removes debris and removable barriers.
- Issues one-hot commands (avancar, girar, remover) to the actuator over a valid/ready handshake.
- Enforces a move budget and reports done when the budget is exhausted.
- Sits between the robot sensor interface and the actuator, replacing free-running per-clock command generation.

Parameters:
CNT_W, 8, width of max_moves and move_count
SETTLE_CYCLES, 1, wait cycles after each accepted command before sensors are sampled again (>=1)
TURN_STEPS, 3, girar commands making one right turn (girar = 90° left)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
start  in  1  begin a run; sampled only in IDLE
max_moves  in  CNT_W  move budget, latched on start
head  in  1  cell ahead blocked
left  in  1  cell to the left blocked
under  in  1  debris under robot
barrier  in  1  blocking cell ahead is removable (meaningful only with head=1)
act_ready  in  1  actuator accepts the current command
avancar  out  1  command: advance one cell
girar  out  1  command: rotate 90° left
remover  out  1  command: remove debris or barrier
busy  out  1  run in progress
done  out  1  budget exhausted
move_count  out  CNT_W  commands accepted this run

Behaviour:
- Reset (reset=0 at rising edge): state IDLE; avancar/girar/remover/busy/done=0; move_count=0; lt_flag=0; remaining=0.
- Reset mid-operation: any in-flight command is dropped, with no partial acceptance.
- Commands are registered and one-hot; at most one is high in any cycle.
- A command is accepted in a cycle where it is high and act_ready=1.
- busy=1 in every state except IDLE and DONE.
- States:
  - IDLE: on start=1, latch remaining=max_moves, clear move_count, mode=SEARCH. If max_moves=0, go to DONE; else go to DECIDE.
  - DECIDE (1 cycle): samples sensors and registers exactly one command into ISSUE (see decision rules below).
  - ISSUE: hold the command stable until act_ready=1. On acceptance: move_count+1, remaining-1, command cleared next cycle. If remaining becomes 0, go to DONE; else go to SETTLE.
  - SETTLE: count SETTLE_CYCLES. Then, if turn_cnt>0, issue girar with turn_cnt-1, skipping sensor sampling; else go to DECIDE.
  - DONE: done=1, held until start=0, then IDLE.
- Decision rules in SEARCH mode, priority order:
  - under -> remover
  - !head -> avancar
  - head & barrier -> remover
  - otherwise -> right turn: girar with turn_cnt=TURN_STEPS-1, mode=FOLLOW
- Decision rules in FOLLOW mode, priority order:
  - under -> remover
  - !left & !lt_flag -> girar, lt_flag=1
  - !head -> avancar, lt_flag=0
  - barrier -> remover
  - otherwise -> right turn as in SEARCH, lt_flag=0
- lt_flag guarantees at most one free-left turn before an advance, preventing spin in open space.
- Sensor values during a right-turn sequence are ignored.
- Budget exhaustion mid right turn goes straight to DONE; remaining girar steps are discarded.
- Counting: move_count saturates at 2^CNT_W-1 and never wraps. start is ignored while busy or in DONE.
- Timing with act_ready=1 and SETTLE_CYCLES=1:
  - Command period: 3 cycles (DECIDE, ISSUE, SETTLE).
  - First command is high 2 cycles after start is sampled.

Test Plan:
1. Mid-run reset: start with max_moves=10, act_ready=0, reset=0 for one edge while avancar=1 -> next cycle all outputs 0, move_count=0, start then re-accepted normally.
2. Zero budget: start with max_moves=0 -> done=1 one cycle later, no command ever asserted, busy stays 0, done drops after start=0.
3. Open-field search: head=left=under=0, act_ready=1, max_moves=3 -> three single-cycle avancar pulses 3 cycles apart, move_count=3, then done=1, busy=0.
4. Wall hit and right turn: search with head=1, barrier=0 -> exactly 3 girar pulses even when head/left toggle between them, then DECIDE in FOLLOW mode. Next, with left=0 and head=0 on two consecutive decisions -> girar then avancar (lt_flag blocks a second girar).
5. Handshake and priority: under=1, head=0, act_ready held 0 for 5 cycles -> remover (not avancar) high and stable 5 cycles, move_count unchanged; act_ready=1 -> accepted, move_count+1. head=1, barrier=1 in FOLLOW with left=1 -> remover.
6. Budget exhausted mid turn: FOLLOW with head=left=1, remaining=2 -> two girar accepted, done=1, third girar never issued, move_count=max_moves.
